// File: rtl/state_sequencer.sv
// rtl/state_sequencer.sv - programmable state-bus stimulus generator with per-step dwell
//
// Plays a stored sequence of up to eight 8-bit states onto state_out. Each
// state is held for H = dwell * DWELL_UNIT cycles (H = 1 when dwell = 0).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data   sequence slot write port (accepted in any state)
//   seq_last, dwell, loop   run configuration, latched when a run starts
//   start, abort        run control (abort has priority)
//   state_out           currently driven state
//   strobe              one-cycle pulse on every step load
//   busy                high while a run is in progress
//   done                one-cycle pulse on normal completion
//   step_idx            slot index currently driven

module state_sequencer #(
    parameter int DWELL_UNIT = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [2:0] seq_last,
    input  logic [3:0] dwell,
    input  logic       loop,
    input  logic       start,
    input  logic       abort,
    output logic [7:0] state_out,
    output logic       strobe,
    output logic       busy,
    output logic       done,
    output logic [2:0] step_idx
);

    // Wide enough for the longest hold (15 steps) minus one, so it never wraps.
    localparam int CW = $clog2(15 * DWELL_UNIT + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } seq_state_t;

    seq_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    dwell_q, dwell_n;
    logic [2:0]    last_q, last_n;
    logic          loop_q, loop_n;
    logic [7:0]    out_n;
    logic [2:0]    idx_n;
    logic          strobe_n, busy_n, done_n;
    logic [2:0]    idx_inc;

    logic [7:0]    mem [8];

    // Counter reload value H-1 for a given dwell setting.
    function automatic logic [CW-1:0] hold_reload(input logic [3:0] d);
        logic [31:0] prod;
        prod = {28'd0, d} * 32'(DWELL_UNIT);
        if (d == 4'd0)
            return '0;
        else
            return CW'(prod - 32'd1);
    endfunction

    // Sequence storage. A write lands on the edge, so a load in the same
    // cycle still sees the previous slot contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                mem[i] <= 8'h00;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign idx_inc = step_idx + 3'd1;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        dwell_n  = dwell_q;
        last_n   = last_q;
        loop_n   = loop_q;
        out_n    = state_out;
        idx_n    = step_idx;
        strobe_n = 1'b0;
        done_n   = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n  = HOLD;
                    dwell_n  = dwell;
                    last_n   = seq_last;
                    loop_n   = loop;
                    idx_n    = 3'd0;
                    out_n    = mem[0];
                    strobe_n = 1'b1;
                    cnt_n    = hold_reload(dwell);
                end
            end
            HOLD: begin
                if (abort) begin
                    // Output and index freeze where they are.
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (step_idx != last_q) begin
                    idx_n    = idx_inc;
                    out_n    = mem[idx_inc];
                    strobe_n = 1'b1;
                    cnt_n    = hold_reload(dwell_q);
                end else if (loop_q) begin
                    idx_n    = 3'd0;
                    out_n    = mem[0];
                    strobe_n = 1'b1;
                    cnt_n    = hold_reload(dwell_q);
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dwell_q   <= 4'd0;
            last_q    <= 3'd0;
            loop_q    <= 1'b0;
            state_out <= 8'h00;
            step_idx  <= 3'd0;
            strobe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dwell_q   <= dwell_n;
            last_q    <= last_n;
            loop_q    <= loop_n;
            state_out <= out_n;
            step_idx  <= idx_n;
            strobe    <= strobe_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_state_sequencer.sv
// tb/tb_state_sequencer.sv - directed self-checking bench for state_sequencer (DWELL_UNIT=4)

module tb_state_sequencer;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] seq_last;
    logic [3:0] dwell;
    logic       loop;
    logic       start;
    logic       abort;
    logic [7:0] state_out;
    logic       strobe;
    logic       busy;
    logic       done;
    logic [2:0] step_idx;

    int total;
    int bad;

    state_sequencer #(.DWELL_UNIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .seq_last  (seq_last),
        .dwell     (dwell),
        .loop      (loop),
        .start     (start),
        .abort     (abort),
        .state_out (state_out),
        .strobe    (strobe),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_slot(input logic [2:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic chk_step(input string tag, input logic [7:0] s, input logic [2:0] idx);
        chk({tag, "_strobe"}, {31'd0, strobe}, 32'd1);
        chk({tag, "_state"}, {24'd0, state_out}, {24'd0, s});
        chk({tag, "_idx"}, {29'd0, step_idx}, {29'd0, idx});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 8'h00;
        seq_last = 3'd0;
        dwell    = 4'd0;
        loop     = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;

        // Reset state
        tick(2);
        chk("rst_state", {24'd0, state_out}, 32'h00);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_strobe", {31'd0, strobe}, 32'd0);
        chk("rst_idx", {29'd0, step_idx}, 32'd0);
        rst_n = 1'b1;
        tick();

        write_slot(3'd0, 8'h11);
        write_slot(3'd1, 8'h22);
        write_slot(3'd2, 8'h33);
        write_slot(3'd3, 8'h44);

        // Basic run: last=2, dwell=1 -> strobes at 1,5,9, done at 13
        seq_last = 3'd2;
        dwell    = 4'd1;
        loop     = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk_step("basic_c1", 8'h11, 3'd0);
        tick();
        chk("basic_c2_strobe", {31'd0, strobe}, 32'd0);
        tick(3);
        chk_step("basic_c5", 8'h22, 3'd1);
        tick(4);
        chk_step("basic_c9", 8'h33, 3'd2);
        tick(3);
        chk("basic_c12_busy", {31'd0, busy}, 32'd1);
        chk("basic_c12_done", {31'd0, done}, 32'd0);
        tick();
        chk("basic_c13_done", {31'd0, done}, 32'd1);
        chk("basic_c13_busy", {31'd0, busy}, 32'd0);
        chk("basic_c13_state", {24'd0, state_out}, 32'h33);
        tick();
        chk("basic_c14_done", {31'd0, done}, 32'd0);
        chk("basic_c14_idx", {29'd0, step_idx}, 32'd2);

        // Minimum dwell: new state every cycle for 4 cycles, then done
        seq_last = 3'd3;
        dwell    = 4'd0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk_step("min_c1", 8'h11, 3'd0);
        tick();
        chk_step("min_c2", 8'h22, 3'd1);
        tick();
        chk_step("min_c3", 8'h33, 3'd2);
        tick();
        chk_step("min_c4", 8'h44, 3'd3);
        tick();
        chk("min_c5_done", {31'd0, done}, 32'd1);
        chk("min_c5_busy", {31'd0, busy}, 32'd0);
        chk("min_c5_strobe", {31'd0, strobe}, 32'd0);
        chk("min_c5_state", {24'd0, state_out}, 32'h44);

        // Loop with abort: 0x11/0x22 alternating every 4 cycles
        seq_last = 3'd1;
        dwell    = 4'd1;
        loop     = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk_step("loop_c1", 8'h11, 3'd0);
        tick(4);
        chk_step("loop_c5", 8'h22, 3'd1);
        tick(4);
        chk_step("loop_c9", 8'h11, 3'd0);
        tick(4);
        chk_step("loop_c13", 8'h22, 3'd1);
        tick(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_state", {24'd0, state_out}, 32'h22);
        chk("abort_idx", {29'd0, step_idx}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_after_done", {31'd0, done}, 32'd0);
            chk("abort_after_strobe", {31'd0, strobe}, 32'd0);
            chk("abort_after_state", {24'd0, state_out}, 32'h22);
        end

        // start together with abort in IDLE: nothing happens
        loop  = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", {31'd0, busy}, 32'd0);
        chk("sa_strobe", {31'd0, strobe}, 32'd0);
        tick();
        chk("sa_busy2", {31'd0, busy}, 32'd0);
        chk("sa_state", {24'd0, state_out}, 32'h22);

        // Mid-run start and config changes are ignored; writes during run
        seq_last = 3'd2;
        dwell    = 4'd1;
        loop     = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk_step("mid_c1", 8'h11, 3'd0);
        tick();
        start    = 1'b1;
        dwell    = 4'd0;
        seq_last = 3'd0;
        loop     = 1'b1;
        tick();
        start    = 1'b0;
        chk("mid_c3_strobe", {31'd0, strobe}, 32'd0);
        chk("mid_c3_idx", {29'd0, step_idx}, 32'd0);
        chk("mid_c3_busy", {31'd0, busy}, 32'd1);
        tick(2);
        chk_step("mid_c5", 8'h22, 3'd1);
        tick();
        write_slot(3'd2, 8'h5A);
        write_slot(3'd1, 8'h77);
        chk("wr_c8_state", {24'd0, state_out}, 32'h22);
        chk("wr_c8_strobe", {31'd0, strobe}, 32'd0);
        tick();
        chk_step("wr_c9", 8'h5A, 3'd2);
        tick(4);
        chk("mid_c13_done", {31'd0, done}, 32'd1);
        chk("mid_c13_busy", {31'd0, busy}, 32'd0);
        chk("mid_c13_state", {24'd0, state_out}, 32'h5A);

        // Asynchronous reset mid-run, then restart plays cleared slot 0
        seq_last = 3'd2;
        dwell    = 4'd1;
        loop     = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk_step("pre_rst_c1", 8'h11, 3'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_state", {24'd0, state_out}, 32'h00);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_strobe", {31'd0, strobe}, 32'd0);
        chk("arst_idx", {29'd0, step_idx}, 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_step("post_rst_c1", 8'h00, 3'd0);
        tick(4);
        chk_step("post_rst_c5", 8'h00, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
